// File: rtl/ball_motion.sv
// Per-frame motion integrator for one metaball: on each falling edge of v_sync it
// advances a 10.2 fixed-point position by a signed velocity that accelerates toward a centre.
// Latency: edge sampled at clock k -> new ball_x/ball_y and frame_tick visible after clock k+3; no backpressure.
//
// Ports:
//   clk_50mhz   in   pixel clock (single clock domain)
//   reset       in   synchronous, active-high
//   v_sync      in   active-low vertical sync, already registered in this domain
//   pause       in   sampled at a detected frame edge; high skips that frame's update
//   ball_x/y    out  integer position (pos[11:2])
//   frame_tick  out  one-cycle pulse when a new position is published
//   frame_count out  committed updates, mod 256
module ball_motion #(
   parameter int START_X   = 224,
   parameter int START_Y   = 157,
   parameter int CENTER_X  = 336,
   parameter int CENTER_Y  = 236,
   parameter int VEL_LIMIT = 255
) (
   input  logic       clk_50mhz,
   input  logic       reset,
   input  logic       v_sync,
   input  logic       pause,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam logic [11:0]        START_X4  = 12'(START_X * 4);
   localparam logic [11:0]        START_Y4  = 12'(START_Y * 4);
   localparam logic [11:0]        CENTER_X4 = 12'(CENTER_X * 4);
   localparam logic [11:0]        CENTER_Y4 = 12'(CENTER_Y * 4);
   localparam logic signed [10:0] VLIM      = 11'(VEL_LIMIT);

   typedef enum logic [1:0] {
      S_WAIT,
      S_STEP_X,
      S_STEP_Y,
      S_COMMIT
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [9:0]  vel_x_q, vel_x_d, vel_y_q, vel_y_d;
   logic [11:0] nx_pos_q, nx_pos_d, ny_pos_q, ny_pos_d;
   logic        vs_q;
   logic        armed_q;
   logic        tick_q, tick_d;
   logic [7:0]  count_q, count_d;

   logic        fall_det;
   logic [11:0] sum_x, sum_y;

   // armed_q stays low until v_sync has been seen high after reset, so a v_sync
   // that is already low at reset release cannot produce an update.
   assign fall_det = vs_q & armed_q & ~v_sync;

   // Position wraps mod 4096: plain 12-bit add of the sign-extended velocity.
   assign sum_x = pos_x_q + {{2{vel_x_q[9]}}, vel_x_q};
   assign sum_y = pos_y_q + {{2{vel_y_q[9]}}, vel_y_q};

   // Step velocity by +-1 toward the attractor, clamped to +-VEL_LIMIT.
   function automatic logic [9:0] sat_vel(input logic [9:0] v, input logic up);
      logic signed [10:0] s;
      s = $signed({v[9], v}) + (up ? 11'sd1 : -11'sd1);
      if (s > VLIM)
         s = VLIM;
      else if (s < -VLIM)
         s = -VLIM;
      return s[9:0];
   endfunction

   always_comb begin
      state_d  = state_q;
      pos_x_d  = pos_x_q;
      pos_y_d  = pos_y_q;
      vel_x_d  = vel_x_q;
      vel_y_d  = vel_y_q;
      nx_pos_d = nx_pos_q;
      ny_pos_d = ny_pos_q;
      tick_d   = 1'b0;
      count_d  = count_q;
      case (state_q)
         S_WAIT: begin
            if (fall_det && !pause)
               state_d = S_STEP_X;
         end
         S_STEP_X: begin
            nx_pos_d = sum_x;
            vel_x_d  = sat_vel(vel_x_q, sum_x < CENTER_X4);
            state_d  = S_STEP_Y;
         end
         S_STEP_Y: begin
            ny_pos_d = sum_y;
            vel_y_d  = sat_vel(vel_y_q, sum_y < CENTER_Y4);
            state_d  = S_COMMIT;
         end
         S_COMMIT: begin
            // Both axes land together so the renderer never sees a half update.
            pos_x_d = nx_pos_q;
            pos_y_d = ny_pos_q;
            tick_d  = 1'b1;
            count_d = count_q + 8'd1;
            state_d = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end

   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         state_q  <= S_WAIT;
         pos_x_q  <= START_X4;
         pos_y_q  <= START_Y4;
         vel_x_q  <= '0;
         vel_y_q  <= '0;
         nx_pos_q <= '0;
         ny_pos_q <= '0;
         vs_q     <= 1'b1;
         armed_q  <= 1'b0;
         tick_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pos_x_q  <= pos_x_d;
         pos_y_q  <= pos_y_d;
         vel_x_q  <= vel_x_d;
         vel_y_q  <= vel_y_d;
         nx_pos_q <= nx_pos_d;
         ny_pos_q <= ny_pos_d;
         vs_q     <= v_sync;
         armed_q  <= armed_q | v_sync;
         tick_q   <= tick_d;
         count_q  <= count_d;
      end
   end

   assign ball_x      = pos_x_q[11:2];
   assign ball_y      = pos_y_q[11:2];
   assign frame_tick  = tick_q;
   assign frame_count = count_q;

endmodule
